// File: rtl/pe_conv_ctrl.sv
// pe_conv_ctrl: walks one 25-tap PE through every input channel of a
// single output pixel, then runs a zero-operand pass to post-process the sum.
module pe_conv_ctrl #(
   parameter int MAX_CIN = 16,
   parameter int CW      = $clog2(MAX_CIN + 1),
   parameter int PE_LAT  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] cin,
   input  logic [31:0]   bias,
   input  logic          relu_cfg,
   input  logic          quan_cfg,
   output logic          busy,
   input  logic          win_ready,
   output logic          win_rd,
   output logic [CW-1:0] ch_addr,
   output logic          op_zero,
   output logic [31:0]   pe_psum,
   output logic          pe_relu_en,
   output logic          pe_quan_en,
   input  logic [31:0]   pe_out,
   output logic [31:0]   result,
   output logic          out_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_FIN,
      S_WAIT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      T_NONE,
      T_PART,
      T_FINAL
   } tag_t;

   localparam logic [CW-1:0] MAX_C = CW'(MAX_CIN);

   state_t        state_q, state_d;
   logic [CW-1:0] cin_q, cin_d;
   logic [CW-1:0] c_q, c_d;
   logic [31:0]   bias_q, bias_d;
   logic          relu_q, relu_d;
   logic          quan_q, quan_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   psum_q, psum_d;
   logic [31:0]   result_q, result_d;
   tag_t          tag_q [PE_LAT];
   tag_t          tag_d [PE_LAT];

   tag_t          tag_in;
   tag_t          tag_out;
   logic          part_busy;
   logic [CW-1:0] cin_clamp;

   assign tag_out   = tag_q[PE_LAT-1];
   assign cin_clamp = (cin > MAX_C) ? MAX_C : cin;

   // A PART still short of the pipe output means acc is not final yet.
   always_comb begin
      part_busy = 1'b0;
      for (int i = 0; i < PE_LAT - 1; i++) begin
         if (tag_q[i] == T_PART) begin
            part_busy = 1'b1;
         end
      end
   end

   always_comb begin
      tag_d[0] = tag_in;
      for (int i = 1; i < PE_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   always_comb begin
      state_d  = state_q;
      cin_d    = cin_q;
      c_d      = c_q;
      bias_d   = bias_q;
      relu_d   = relu_q;
      quan_d   = quan_q;
      acc_d    = acc_q;
      psum_d   = '0;
      result_d = result_q;
      tag_in   = T_NONE;
      win_rd   = 1'b0;
      op_zero  = 1'b0;

      if (tag_out == T_PART) begin
         acc_d = acc_q + pe_out;
      end
      if (tag_out == T_FINAL) begin
         result_d = pe_out;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cin_d  = cin_clamp;
               bias_d = bias;
               relu_d = relu_cfg;
               quan_d = quan_cfg;
               c_d    = '0;
               if (cin_clamp == '0) begin
                  acc_d   = bias;
                  state_d = S_FIN;
               end else begin
                  acc_d   = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (win_ready) begin
               win_rd = 1'b1;
               tag_in = T_PART;
               if (c_q == '0) begin
                  psum_d = bias_q;
               end
               if (c_q == cin_q - CW'(1)) begin
                  state_d = S_DRAIN;
               end else begin
                  c_d = c_q + CW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (!part_busy) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            op_zero = 1'b1;
            tag_in  = T_FINAL;
            psum_d  = acc_q;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tag_out == T_FINAL) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cin_q    <= '0;
         c_q      <= '0;
         bias_q   <= '0;
         relu_q   <= 1'b0;
         quan_q   <= 1'b0;
         acc_q    <= '0;
         psum_q   <= '0;
         result_q <= '0;
         for (int i = 0; i < PE_LAT; i++) begin
            tag_q[i] <= T_NONE;
         end
      end else begin
         state_q  <= state_d;
         cin_q    <= cin_d;
         c_q      <= c_d;
         bias_q   <= bias_d;
         relu_q   <= relu_d;
         quan_q   <= quan_d;
         acc_q    <= acc_d;
         psum_q   <= psum_d;
         result_q <= result_d;
         for (int i = 0; i < PE_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN) ||
                       (state_q == S_FIN)   || (state_q == S_WAIT);
   assign out_valid  = (state_q == S_DONE);
   assign ch_addr    = c_q;
   assign pe_psum    = psum_q;
   assign result     = result_q;
   // Post-processing only touches the final pass; partials stay raw.
   assign pe_relu_en = relu_q && (tag_out == T_FINAL);
   assign pe_quan_en = quan_q && (tag_out == T_FINAL);

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Bench for pe_conv_ctrl: behavioural PE + window buffer, vector table,
// reset-abort sequence and randomized transactions.
module tb_pe_conv_ctrl;

   localparam int MAX_CIN = 16;
   localparam int CW      = 5;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          start     = 1'b0;
   logic [CW-1:0] cin       = '0;
   logic [31:0]   bias      = '0;
   logic          relu_cfg  = 1'b0;
   logic          quan_cfg  = 1'b0;
   logic          win_ready = 1'b1;
   logic          busy;
   logic          win_rd;
   logic [CW-1:0] ch_addr;
   logic          op_zero;
   logic [31:0]   pe_psum;
   logic          pe_relu_en;
   logic          pe_quan_en;
   logic [31:0]   pe_out;
   logic [31:0]   result;
   logic          out_valid;

   int checks   = 0;
   int failures = 0;

   int if_mem [MAX_CIN][25];
   int w_mem  [MAX_CIN][25];

   logic [31:0] p1 = '0;
   logic [31:0] p2 = '0;
   logic [31:0] p3 = '0;
   logic [31:0] p4 = '0;

   pe_conv_ctrl #(.MAX_CIN(MAX_CIN)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cin        (cin),
      .bias       (bias),
      .relu_cfg   (relu_cfg),
      .quan_cfg   (quan_cfg),
      .busy       (busy),
      .win_ready  (win_ready),
      .win_rd     (win_rd),
      .ch_addr    (ch_addr),
      .op_zero    (op_zero),
      .pe_psum    (pe_psum),
      .pe_relu_en (pe_relu_en),
      .pe_quan_en (pe_quan_en),
      .pe_out     (pe_out),
      .result     (result),
      .out_valid  (out_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] dot(input int ch);
      logic [31:0] s;
      s = '0;
      if (ch >= MAX_CIN) return '0;
      for (int i = 0; i < 25; i++) s += 32'(if_mem[ch][i] * w_mem[ch][i]);
      return s;
   endfunction

   function automatic logic [31:0] pe_post(input logic [31:0] v,
                                           input logic relu,
                                           input logic quan);
      int s;
      int q;
      s = v;
      if (relu && s < 0) s = 0;
      if (quan) begin
         if (s < 0) q = 0;
         else if (s > 32767) q = 255;
         else begin
            q = (s >>> 7) + ((s >>> 6) & 1);
            if (q > 255) q = 255;
         end
         s = q;
      end
      return s;
   endfunction

   // PE: operands at k, psum at k+1, pe_out at k+4.
   always @(posedge clk) begin
      p1 <= (win_rd && !op_zero) ? dot(int'(ch_addr)) : 32'd0;
      p2 <= p1 + pe_psum;
      p3 <= p2;
      p4 <= p3;
   end
   assign pe_out = pe_post(p4, pe_relu_en, pe_quan_en);

   function automatic int clampc(input int c);
      return (c > MAX_CIN) ? MAX_CIN : c;
   endfunction

   function automatic logic rdy(input logic [63:0] m, input int t);
      return (t < 64) ? !m[t] : 1'b1;
   endfunction

   function automatic logic [31:0] raw_sum(input int c, input logic [31:0] b);
      logic [31:0] s;
      s = b;
      for (int ch = 0; ch < clampc(c); ch++) s += dot(ch);
      return s;
   endfunction

   function automatic int ov_cycle(input int c, input logic [63:0] m);
      int n;
      n = 0;
      if (c == 0) return 6;
      for (int t = 1; t < 200; t++) begin
         if (rdy(m, t)) begin
            n++;
            if (n == c) return t + 10;
         end
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_const(input int ifv, input int wv);
      for (int c = 0; c < MAX_CIN; c++)
         for (int i = 0; i < 25; i++) begin
            if_mem[c][i] = ifv;
            w_mem[c][i]  = wv;
         end
   endtask

   task automatic load_rand();
      for (int c = 0; c < MAX_CIN; c++)
         for (int i = 0; i < 25; i++) begin
            if_mem[c][i] = int'($urandom_range(0, 255));
            w_mem[c][i]  = int'($urandom_range(0, 255)) - 128;
         end
   endtask

   task automatic run(input string tag, input int c_in, input logic [31:0] b,
                      input logic rl, input logic qn, input logic [63:0] m,
                      input logic [31:0] exp_res, input int exp_ov);
      int c;
      int n;
      logic exp_rd;
      logic prev_ch0;
      logic [31:0] acc_exp;
      logic [31:0] exp_psum;
      c        = clampc(c_in);
      n        = 0;
      prev_ch0 = 1'b0;
      acc_exp  = raw_sum(c_in, b);
      @(posedge clk);
      #1;
      start     = 1'b1;
      cin       = CW'(c_in);
      bias      = b;
      relu_cfg  = rl;
      quan_cfg  = qn;
      win_ready = rdy(m, 0);
      @(negedge clk);
      chk($sformatf("%s busy t=0", tag), busy, 0);
      for (int t = 1; t <= exp_ov + 1 && t < 200; t++) begin
         @(posedge clk);
         #1;
         start     = (t == exp_ov) ||
                     (t < exp_ov && $urandom_range(0, 3) == 0);
         cin       = CW'($urandom_range(0, 16));
         bias      = $urandom;
         relu_cfg  = 1'($urandom);
         quan_cfg  = 1'($urandom);
         win_ready = rdy(m, t);
         @(negedge clk);
         exp_rd = (n < c) && rdy(m, t);
         chk($sformatf("%s win_rd t=%0d", tag, t), win_rd, exp_rd);
         if (n < c)
            chk($sformatf("%s ch_addr t=%0d", tag, t), ch_addr, n);
         exp_psum = prev_ch0 ? b : ((t == exp_ov - 4) ? acc_exp : 32'd0);
         chk($sformatf("%s pe_psum t=%0d", tag, t), pe_psum, exp_psum);
         prev_ch0 = exp_rd && (n == 0);
         if (exp_rd) n++;
         chk($sformatf("%s op_zero t=%0d", tag, t), op_zero, t == exp_ov - 5);
         chk($sformatf("%s busy t=%0d", tag, t), busy, t < exp_ov);
         chk($sformatf("%s out_valid t=%0d", tag, t), out_valid, t == exp_ov);
         chk($sformatf("%s relu_en t=%0d", tag, t), pe_relu_en,
             rl && (t == exp_ov - 1));
         chk($sformatf("%s quan_en t=%0d", tag, t), pe_quan_en,
             qn && (t == exp_ov - 1));
         if (t == exp_ov)
            chk($sformatf("%s result", tag), result, exp_res);
      end
      start = 1'b0;
   endtask

   typedef struct {
      int          cin;
      logic [31:0] bias;
      logic        relu;
      logic        quan;
      int          ifv;
      int          wv;
      logic [63:0] mask;
      logic [31:0] res;
      int          ov;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int c_r;
      logic [31:0] b_r;
      logic rl_r;
      logic qn_r;
      logic [63:0] m_r;

      tbl[0] = '{3, 32'd10, 1'b0, 1'b0, 1, 1, 64'h0, 32'd85, 13};
      tbl[1] = '{3, 32'd10, 1'b0, 1'b1, 1, 1, 64'h0, 32'd1, 13};
      tbl[2] = '{3, 32'd0, 1'b1, 1'b0, 1, -1, 64'h0, 32'd0, 13};
      tbl[3] = '{16, 32'd0, 1'b0, 1'b1, 255, 127, 64'h0, 32'd255, 26};
      tbl[4] = '{3, 32'd10, 1'b0, 1'b0, 1, 1, 64'hC, 32'd85, 15};
      tbl[5] = '{0, 32'hFFFF_FFFB, 1'b1, 1'b0, 1, 1, 64'h0, 32'd0, 6};
      tbl[6] = '{0, 32'hFFFF_FFFB, 1'b0, 1'b0, 1, 1, 64'h0,
                 32'hFFFF_FFFB, 6};
      tbl[7] = '{20, 32'd0, 1'b0, 1'b0, 1, 1, 64'h0, 32'd400, 26};

      #1;
      chk("rst busy", busy, 0);
      chk("rst win_rd", win_rd, 0);
      chk("rst op_zero", op_zero, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst relu_en", pe_relu_en, 0);
      chk("rst quan_en", pe_quan_en, 0);
      chk("rst ch_addr", ch_addr, 0);
      chk("rst pe_psum", pe_psum, 0);
      chk("rst result", result, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         load_const(tbl[i].ifv, tbl[i].wv);
         run($sformatf("vec%0d", i), tbl[i].cin, tbl[i].bias, tbl[i].relu,
             tbl[i].quan, tbl[i].mask, tbl[i].res, tbl[i].ov);
      end

      // abort test 1 mid-flight: rst low cycles 4-5, released in cycle 6
      load_const(1, 1);
      @(posedge clk);
      #1;
      start    = 1'b1;
      cin      = 5'd3;
      bias     = 32'd10;
      relu_cfg = 1'b0;
      quan_cfg = 1'b0;
      win_ready = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort busy", busy, 0);
      chk("abort win_rd", win_rd, 0);
      chk("abort op_zero", op_zero, 0);
      chk("abort out_valid", out_valid, 0);
      chk("abort relu_en", pe_relu_en, 0);
      chk("abort ch_addr", ch_addr, 0);
      chk("abort pe_psum", pe_psum, 0);
      chk("abort result", result, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         chk($sformatf("post-abort idle t=%0d", t), {out_valid, busy}, 0);
      end
      run("rerun", 3, 32'd10, 1'b0, 1'b0, 64'h0, 32'd85, 13);

      for (int k = 0; k < 40; k++) begin
         load_rand();
         c_r  = int'($urandom_range(0, 18));
         b_r  = ($urandom_range(0, 1) == 1) ? $urandom :
                32'(int'($urandom_range(0, 2000)) - 1000);
         rl_r = 1'($urandom);
         qn_r = 1'($urandom);
         m_r  = {$urandom, $urandom} & {$urandom, $urandom};
         run($sformatf("rnd%0d", k), c_r, b_r, rl_r, qn_r, m_r,
             pe_post(raw_sum(c_r, b_r), rl_r, qn_r),
             ov_cycle(clampc(c_r), m_r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
